ebuf_rd_skp_stripper: RTL and testbench

//  Consumer at the far end of the elastic-buffer read stream (data/vld, no backpressure).

---
 rtl/ebuf_pkg.sv | 14 +
 rtl/stream_skid_fifo.sv | 53 +++++
 rtl/ebuf_rd_skp_stripper.sv | 116 +++++++++++
 tb/tb_ebuf_rd_skp_stripper.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ebuf_pkg.sv
// Shared types and symbol defaults for the elastic-buffer read side.
// The bench reuses the symbol codes so its sequences match the RTL.
package ebuf_pkg;

   typedef enum logic {
      S_DATA,
      S_OS
   } skp_strip_state_e;

   localparam logic [19:0] COM_SYM_DEF = 20'h000FA;
   localparam logic [19:0] SKP_SYM_DEF = 20'h000F4;
   localparam int          MAX_SKP_DEF = 5;

endpackage

// File: rtl/stream_skid_fifo.sv
// Small ring-buffer FIFO with a valid/ready output port.
// A full FIFO still accepts a push when the head is popped in the same cycle.
module stream_skid_fifo #(
   parameter int DATA_WIDTH = 20,
   parameter int DEPTH      = 2
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] push_data,
   output logic                  full,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_vld,
   input  logic                  out_rdy
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]         wr_ptr;
   logic [AW-1:0]         rd_ptr;
   logic [CW-1:0]         count;
   logic                  pop;
   logic                  accept;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign out_vld  = (count != '0);
   assign full     = (count == CW'(DEPTH));
   assign pop      = out_vld & out_rdy;
   assign accept   = push & (~full | pop);
   assign out_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (pop) rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(accept) - CW'(pop);
      end
   end

endmodule

// File: rtl/ebuf_rd_skp_stripper.sv
// Strips SKP ordered sets from the elastic-buffer read stream and
// forwards the remaining words through a skid FIFO, with OS statistics.
module ebuf_rd_skp_stripper
   import ebuf_pkg::*;
#(
   parameter int                    DATA_WIDTH = 20,
   parameter logic [DATA_WIDTH-1:0] COM_SYM    = DATA_WIDTH'(COM_SYM_DEF),
   parameter logic [DATA_WIDTH-1:0] SKP_SYM    = DATA_WIDTH'(SKP_SYM_DEF),
   parameter int                    MAX_SKP    = MAX_SKP_DEF,
   parameter int                    CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  arst,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  vld_in,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [CNT_WIDTH-1:0]  os_cnt,
   output logic                  os_err,
   output logic                  ovf
);

   localparam int SW = $clog2(MAX_SKP + 2);
   localparam logic [SW-1:0] SKP_SAT = SW'(MAX_SKP + 1);
   localparam logic [SW-1:0] SKP_MAX = SW'(MAX_SKP);

   skp_strip_state_e state, state_nxt;
   logic [SW-1:0]    skp_cnt, skp_nxt;
   logic             push;
   logic             close_os;
   logic             orphan;
   logic             legal;
   logic             is_com;
   logic             is_skp;
   logic             full;
   logic             drop;

   assign is_com = (data_in == COM_SYM);
   assign is_skp = (data_in == SKP_SYM);

   always_comb begin
      state_nxt = state;
      skp_nxt   = skp_cnt;
      push      = 1'b0;
      close_os  = 1'b0;
      orphan    = 1'b0;
      if (vld_in) begin
         unique case (state)
            S_DATA: begin
               unique case (1'b1)
                  is_com: begin
                     skp_nxt   = '0;
                     state_nxt = S_OS;
                  end
                  is_skp:  orphan = 1'b1;
                  default: push = 1'b1;
               endcase
            end
            S_OS: begin
               unique case (1'b1)
                  is_skp: begin
                     if (skp_cnt != SKP_SAT) skp_nxt = skp_cnt + SW'(1);
                  end
                  is_com: begin
                     close_os = 1'b1;
                     skp_nxt  = '0;
                  end
                  default: begin
                     close_os  = 1'b1;
                     push      = 1'b1;
                     state_nxt = S_DATA;
                  end
               endcase
            end
            default: state_nxt = S_DATA;
         endcase
      end
   end

   assign legal = close_os && (skp_cnt != '0) && (skp_cnt <= SKP_MAX);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= S_DATA;
         skp_cnt <= '0;
         os_cnt  <= '0;
         os_err  <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         state   <= state_nxt;
         skp_cnt <= skp_nxt;
         os_err  <= orphan | (close_os & ~legal);
         if (legal && (os_cnt != '1)) os_cnt <= os_cnt + CNT_WIDTH'(1);
         if (drop) ovf <= 1'b1;
      end
   end

   // A push into a full FIFO survives only if the head leaves this cycle
   assign drop = push & full & ~(out_vld & out_rdy);

   stream_skid_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (2)
   ) u_fifo (
      .clk      (clk),
      .arst     (arst),
      .push     (push),
      .push_data(data_in),
      .full     (full),
      .out_data (out_data),
      .out_vld  (out_vld),
      .out_rdy  (out_rdy)
   );

endmodule

// File: tb/tb_ebuf_rd_skp_stripper.sv
// Directed bench for the SKP stripper with an independent queue-based model.
module tb_ebuf_rd_skp_stripper;
   import ebuf_pkg::*;

   localparam int CW  = 4;
   localparam int MAXS = MAX_SKP_DEF;
   localparam logic [19:0] COM = COM_SYM_DEF;
   localparam logic [19:0] SKP = SKP_SYM_DEF;

   logic          clk = 1'b0;
   logic          arst;
   logic [19:0]   data_in;
   logic          vld_in;
   logic [19:0]   out_data;
   logic          out_vld;
   logic          out_rdy;
   logic [CW-1:0] os_cnt;
   logic          os_err;
   logic          ovf;

   ebuf_rd_skp_stripper #(
      .DATA_WIDTH(20),
      .CNT_WIDTH (CW)
   ) dut (
      .clk     (clk),
      .arst    (arst),
      .data_in (data_in),
      .vld_in  (vld_in),
      .out_data(out_data),
      .out_vld (out_vld),
      .out_rdy (out_rdy),
      .os_cnt  (os_cnt),
      .os_err  (os_err),
      .ovf     (ovf)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   // Behavioural model: words, OS count (unbounded), error flag, overflow
   logic [19:0] mq[$];
   bit          in_os;
   int          nskp;
   int          mcnt;
   bit          m_err;
   bit          m_ovf;

   always @(posedge clk or posedge arst) begin
      if (arst) begin
         mq.delete();
         in_os = 0;
         nskp  = 0;
         mcnt  = 0;
         m_err = 0;
         m_ovf = 0;
      end else begin
         int   sz;
         bit   pop;
         bit   have;
         logic [19:0] w;
         sz    = mq.size();
         pop   = (sz > 0) && out_rdy;
         m_err = 0;
         have  = 0;
         w     = data_in;
         if (vld_in) begin
            if (!in_os) begin
               if (w == COM) begin
                  in_os = 1;
                  nskp  = 0;
               end else if (w == SKP) m_err = 1;
               else have = 1;
            end else if (w == SKP) begin
               nskp++;
            end else begin
               if (nskp >= 1 && nskp <= MAXS) mcnt++;
               else m_err = 1;
               if (w == COM) nskp = 0;
               else begin
                  in_os = 0;
                  have  = 1;
               end
            end
         end
         if (have) begin
            if (sz < 2 || pop) mq.push_back(w);
            else m_ovf = 1;
         end
         if (pop) void'(mq.pop_front());
      end
   end

   // Per-cycle compare plus capture of delivered words and error pulses
   logic [19:0] got[$];
   int          err_seen = 0;

   always @(negedge clk) begin
      chk("out_vld", out_vld, mq.size() > 0);
      if (mq.size() > 0) chk("out_data", out_data, mq[0]);
      chk("os_cnt", os_cnt, (mcnt > 15) ? 15 : mcnt);
      chk("os_err", os_err, m_err);
      chk("ovf", ovf, m_ovf);
      if (arst) chk("rst_out_data", out_data, 0);
      if (out_vld && out_rdy) got.push_back(out_data);
      if (os_err) err_seen++;
   end

   task automatic send(input logic [19:0] w);
      data_in = w;
      vld_in  = 1'b1;
      @(posedge clk);
      #2;
      vld_in  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 20 && mq.size() != 0; i++) idle(1);
      idle(2);
      chk("drain_bound", mq.size(), 0);
   endtask

   localparam logic [19:0] WA = 20'h00101, WB = 20'h00202, WC = 20'h00303;
   localparam logic [19:0] WD = 20'h00404, WE = 20'h00505, WF = 20'h00606;
   localparam logic [19:0] WG = 20'h00707, WH = 20'h00808, WD2 = 20'h00909;
   localparam logic [19:0] X1 = 20'h01111, X2 = 20'h02222, X3 = 20'h03333;

   int e0;

   initial begin
      arst    = 1'b1;
      vld_in  = 1'b0;
      data_in = '0;
      out_rdy = 1'b1;
      idle(3);
      chk("rst_vld", out_vld, 0);
      chk("rst_cnt", os_cnt, 0);
      chk("rst_ovf", ovf, 0);
      arst = 1'b0;
      idle(2);

      // 1: basic strip, one-cycle latency
      got.delete(); e0 = err_seen;
      send(WA);
      chk("t1_lat_vld", out_vld, 1);
      chk("t1_lat_data", out_data, WA);
      send(WB); send(COM); send(SKP); send(SKP); send(WC);
      drain();
      chk("t1_n", got.size(), 3);
      chk("t1_w0", got[0], WA);
      chk("t1_w1", got[1], WB);
      chk("t1_w2", got[2], WC);
      chk("t1_cnt", os_cnt, 1);
      chk("t1_err", err_seen - e0, 0);

      // 2: too many SKPs, then exactly MAX_SKP
      got.delete(); e0 = err_seen;
      send(COM);
      repeat (6) send(SKP);
      send(WD);
      drain();
      chk("t2_n", got.size(), 1);
      chk("t2_w0", got[0], WD);
      chk("t2_cnt", os_cnt, 1);
      chk("t2_err", err_seen - e0, 1);
      got.delete(); e0 = err_seen;
      send(COM);
      repeat (MAXS) send(SKP);
      send(WD2);
      drain();
      chk("t2b_w0", got[0], WD2);
      chk("t2b_cnt", os_cnt, 2);
      chk("t2b_err", err_seen - e0, 0);

      // 3: bare COM followed by legal OS
      got.delete(); e0 = err_seen;
      send(COM); send(COM); send(SKP); send(WE);
      drain();
      chk("t3_w0", got[0], WE);
      chk("t3_cnt", os_cnt, 3);
      chk("t3_err", err_seen - e0, 1);

      // 4: orphan SKP
      got.delete(); e0 = err_seen;
      send(SKP);
      drain();
      chk("t4_n", got.size(), 0);
      chk("t4_cnt", os_cnt, 3);
      chk("t4_err", err_seen - e0, 1);

      // 5: overflow with downstream stalled
      got.delete();
      out_rdy = 1'b0;
      send(X1); send(X2); send(X3);
      idle(3);
      chk("t5_ovf", ovf, 1);
      chk("t5_hold", out_data, X1);
      out_rdy = 1'b1;
      drain();
      chk("t5_n", got.size(), 2);
      chk("t5_w0", got[0], X1);
      chk("t5_w1", got[1], X2);
      chk("t5_ovf_sticky", ovf, 1);

      // 6: reset in the middle of an OS
      send(COM); send(SKP);
      arst = 1'b1;
      idle(2);
      arst = 1'b0;
      idle(1);
      got.delete(); e0 = err_seen;
      send(WF);
      drain();
      chk("t6_w0", got[0], WF);
      chk("t6_cnt", os_cnt, 0);
      chk("t6_err", err_seen - e0, 0);
      chk("t6_ovf", ovf, 0);

      // 7: vld gaps inside an OS
      got.delete(); e0 = err_seen;
      send(COM); idle(1); send(SKP); idle(2); send(WG);
      drain();
      chk("t7_w0", got[0], WG);
      chk("t7_cnt", os_cnt, 1);
      chk("t7_err", err_seen - e0, 0);

      // 8: counter saturation (4-bit counter)
      got.delete(); e0 = err_seen;
      repeat (20) begin
         send(COM);
         send(SKP);
      end
      send(WH);
      drain();
      chk("t8_w0", got[0], WH);
      chk("t8_cnt", os_cnt, 15);
      chk("t8_err", err_seen - e0, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
